mc_control_unit: RTL and testbench
==================================

Name: mc_control_unit

Overview:
- Next-generation multicycle MIPS-subset control FSM driving the shared-ALU, single-memory datapath.
- Adds the following over the previous control unit:
  - LW, SW and BNE support.
  - Memory wait-state handshake.
  - Parametrised opcode width and a 2-bit ALUOp.
  - Sticky illegal-opcode trap.
- Sits between the instruction register opcode field and all datapath mux selects and write enables. All outputs are Moore-decoded from the registered state, except the two enables gated by mem_ready.

Parameters:
- OP_W, 6, opcode field width; opcode constants are zero-extended to OP_W.
- TRAP_ON_ILLEGAL, 1, 1: an unknown opcode enters TRAP; 0: an unknown opcode is treated as a NOP and returns to FETCH.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- opCode  in  OP_W  IR[31:26], stable from DECODE onward
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access requested (FETCH, MEM_READ, MEM_WRITE)
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  conditional PC load, qualified by the datapath Zero flag
- BranchNe  out  1  1: PCWriteCond qualifies on !Zero (BNE); 0: on Zero (BEQ)
- IorD  out  1  memory address mux: 0 = PC, 1 = ALUOut
- MemWrite  out  1  memory write strobe
- MemtoReg  out  1  register write-data mux: 1 = MDR
- IRWrite  out  1  IR load
- RegWrite  out  1  register file write
- RegDst  out  1  1 = rd, 0 = rt
- ALUSrcA  out  1  0 = PC, 1 = A
- ALUSrcB  out  2  00 = B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
- ALUOp  out  2  00 = add, 01 = sub, 10 = funct-decoded
- PCSource  out  2  00 = ALU, 01 = ALUOut, 10 = jump target
- instr_done  out  1  1-cycle pulse on the final cycle of each retired instruction
- illegal  out  1  sticky; high while in TRAP

Behaviour:
- Reset:
  - A rising clk edge with reset=1 sets state=FETCH.
  - While reset=1, all outputs are forced to 0 combinationally, including mem_req, illegal and instr_done.
- Default: every output not listed for a state is 0.
- FETCH:
  - Drives mem_req=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite=PCWrite=mem_ready.
  - Stays in FETCH while mem_ready=0; moves to DECODE when mem_ready=1.
- DECODE:
  - Drives ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut).
  - Next state by opcode:
    - R(000000) -> R_EXEC
    - ADDI(001000) -> I_EXEC
    - LW(100011) or SW(101011) -> MEM_ADDR
    - BEQ(000100) or BNE(000101) -> BRANCH
    - J(000010) -> JUMP
    - any other opcode -> TRAP if TRAP_ON_ILLEGAL, else FETCH with instr_done=1
- R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> R_WB.
- R_WB: RegDst=1, RegWrite=1, MemtoReg=0, instr_done=1 -> FETCH.
- I_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> I_WB.
- I_WB: RegDst=0, RegWrite=1, MemtoReg=0, instr_done=1 -> FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> MEM_READ for LW, MEM_WRITE for SW.
- MEM_READ: mem_req=1, IorD=1. Waits for mem_ready, then -> MEM_WB. The MDR is loaded every cycle by the datapath.
- MEM_WB: RegDst=0, MemtoReg=1, RegWrite=1, instr_done=1 -> FETCH.
- MEM_WRITE:
  - mem_req=1, IorD=1, MemWrite=1; MemWrite is held until mem_ready.
  - On mem_ready=1: instr_done=1 -> FETCH.
- BRANCH:
  - ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01, PCWriteCond=1.
  - BranchNe=1 when opCode=BNE.
  - instr_done=1 -> FETCH.
- JUMP: PCSource=10, PCWrite=1, instr_done=1 -> FETCH.
- TRAP: illegal=1, all enables 0; leaves TRAP only on reset.
- Latency with zero memory waits:
  - R and ADDI: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BEQ, BNE and J: 3 cycles.
  - Each mem_ready=0 cycle adds one cycle.
- mem_ready is ignored in every non-memory state.
- A reset asserted mid-instruction abandons the instruction. No write enable fires on the cycle reset is sampled high.
- State encoding: 4-bit binary. Unused encodings go to FETCH.

Decomposition:
- Package mc_ctrl_pkg holds:
  - the state enum (13 states)
  - opcode constants
  - ALUOp constants (ADD, SUB, FUNCT)
  - ALUSrcB and PCSource select constants
- No sub-module. A single FSM with a next-state block and an output-decode block.

Test Plan:
- Reset, then opCode=000000 with mem_ready=1 held -> states FETCH, DECODE, R_EXEC, R_WB. RegWrite=1 and RegDst=1 only in cycle 4; instr_done pulses in cycle 4.
- LW (100011) with mem_ready=0 for 2 cycles in FETCH and 3 in MEM_READ -> 10-cycle instruction. IRWrite and PCWrite are high exactly once. MemtoReg=1 and RegWrite=1 in the final cycle.
- SW (101011) with mem_ready=0 for 1 cycle in MEM_WRITE -> MemWrite=1 for 2 consecutive cycles with IorD=1; RegWrite is never 1.
- BNE (000101) -> in cycle 3, PCWriteCond=1, BranchNe=1, ALUOp=01, PCSource=01. BEQ gives the same response except BranchNe=0.
- Opcode 111111 with TRAP_ON_ILLEGAL=1 -> illegal=1 from cycle 3 onward and all enables 0 for 20 cycles. Then reset=1 for one edge -> state FETCH, illegal=0. With TRAP_ON_ILLEGAL=0 -> FETCH in cycle 3, instr_done=1 in cycle 2.
- Assert reset during MEM_WRITE -> MemWrite=0 in that cycle. The next cycle is FETCH with mem_req=1 and IorD=0.

Source files
------------

// File: rtl/mc_control_unit_pkg.sv
// ---------------------------------------------------------------------------
// mc_ctrl_pkg
// Shared types and constants for the multicycle MIPS-subset control unit:
// the 13-state FSM encoding, the instruction opcodes the FSM understands,
// and the encodings of the ALUOp, ALUSrcB and PCSource datapath selects.
// ---------------------------------------------------------------------------
package mc_ctrl_pkg;

  // Four-bit binary state encoding; 4'd13..4'd15 are unused and recover to FETCH.
  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_R_EXEC    = 4'd2,
    S_R_WB      = 4'd3,
    S_I_EXEC    = 4'd4,
    S_I_WB      = 4'd5,
    S_MEM_ADDR  = 4'd6,
    S_MEM_READ  = 4'd7,
    S_MEM_WB    = 4'd8,
    S_MEM_WRITE = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11,
    S_TRAP      = 4'd12
  } state_t;

  // Opcodes as they appear in IR[31:26]; zero-extended to the opcode width in use.
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ALUB_REG    = 2'b00;
  localparam logic [1:0] ALUB_FOUR   = 2'b01;
  localparam logic [1:0] ALUB_IMM    = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_control_unit_if.sv
// ---------------------------------------------------------------------------
// mc_control_unit_if
// Bundle between the control unit and the datapath/memory.
//   opCode, mem_ready          : datapath -> control (IR opcode, memory done)
//   mem_req .. PCSource        : control -> datapath (selects and enables)
//   instr_done, illegal        : control status
// modport master: the control unit.  modport slave: the datapath side.
// ---------------------------------------------------------------------------
interface mc_control_unit_if #(
  parameter int OP_W = 6
);
  logic [OP_W-1:0] opCode;
  logic            mem_ready;
  logic            mem_req;
  logic            PCWrite;
  logic            PCWriteCond;
  logic            BranchNe;
  logic            IorD;
  logic            MemWrite;
  logic            MemtoReg;
  logic            IRWrite;
  logic            RegWrite;
  logic            RegDst;
  logic            ALUSrcA;
  logic [1:0]      ALUSrcB;
  logic [1:0]      ALUOp;
  logic [1:0]      PCSource;
  logic            instr_done;
  logic            illegal;

  modport master (
    input  opCode, mem_ready,
    output mem_req, PCWrite, PCWriteCond, BranchNe, IorD, MemWrite, MemtoReg,
           IRWrite, RegWrite, RegDst, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           instr_done, illegal
  );

  modport slave (
    output opCode, mem_ready,
    input  mem_req, PCWrite, PCWriteCond, BranchNe, IorD, MemWrite, MemtoReg,
           IRWrite, RegWrite, RegDst, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           instr_done, illegal
  );
endinterface

// File: rtl/mc_control_unit.sv
// ---------------------------------------------------------------------------
// mc_control_unit
// Multicycle MIPS-subset control FSM (R-type, ADDI, LW, SW, BEQ, BNE, J) for
// a shared-ALU, single-memory datapath, with a memory wait-state handshake
// and a sticky illegal-opcode trap.
// Ports:
//   clk    : clock
//   reset  : synchronous active-high reset; also forces every output to 0
//   bus    : mc_control_unit_if.master (opCode/mem_ready in, all selects,
//            enables and status out)
// Parameters:
//   OP_W            : opcode width (must match the interface)
//   TRAP_ON_ILLEGAL : 1 = unknown opcode traps, 0 = treated as a NOP
// ---------------------------------------------------------------------------
module mc_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter int OP_W            = 6,
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  mc_control_unit_if.master bus
);

  localparam logic [OP_W-1:0] OPC_R    = OP_W'(OP_RTYPE);
  localparam logic [OP_W-1:0] OPC_ADDI = OP_W'(OP_ADDI);
  localparam logic [OP_W-1:0] OPC_LW   = OP_W'(OP_LW);
  localparam logic [OP_W-1:0] OPC_SW   = OP_W'(OP_SW);
  localparam logic [OP_W-1:0] OPC_BEQ  = OP_W'(OP_BEQ);
  localparam logic [OP_W-1:0] OPC_BNE  = OP_W'(OP_BNE);
  localparam logic [OP_W-1:0] OPC_J    = OP_W'(OP_J);

  state_t r_state;
  state_t w_nextState;

  logic w_isR, w_isAddi, w_isLw, w_isSw, w_isBeq, w_isBne, w_isJ;

  // Opcode decode, shared by the next-state and output logic.
  always_comb begin
    w_isR    = (bus.opCode == OPC_R);
    w_isAddi = (bus.opCode == OPC_ADDI);
    w_isLw   = (bus.opCode == OPC_LW);
    w_isSw   = (bus.opCode == OPC_SW);
    w_isBeq  = (bus.opCode == OPC_BEQ);
    w_isBne  = (bus.opCode == OPC_BNE);
    w_isJ    = (bus.opCode == OPC_J);
  end

  // Next-state logic. mem_ready only matters in the three memory states;
  // TRAP is absorbing and any unused encoding recovers to FETCH.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_FETCH:     if (bus.mem_ready) w_nextState = S_DECODE;
      S_DECODE: begin
        if (w_isR)                     w_nextState = S_R_EXEC;
        else if (w_isAddi)             w_nextState = S_I_EXEC;
        else if (w_isLw || w_isSw)     w_nextState = S_MEM_ADDR;
        else if (w_isBeq || w_isBne)   w_nextState = S_BRANCH;
        else if (w_isJ)                w_nextState = S_JUMP;
        else if (TRAP_ON_ILLEGAL)      w_nextState = S_TRAP;
        else                           w_nextState = S_FETCH;
      end
      S_R_EXEC:    w_nextState = S_R_WB;
      S_R_WB:      w_nextState = S_FETCH;
      S_I_EXEC:    w_nextState = S_I_WB;
      S_I_WB:      w_nextState = S_FETCH;
      S_MEM_ADDR:  w_nextState = w_isLw ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  if (bus.mem_ready) w_nextState = S_MEM_WB;
      S_MEM_WB:    w_nextState = S_FETCH;
      S_MEM_WRITE: if (bus.mem_ready) w_nextState = S_FETCH;
      S_BRANCH:    w_nextState = S_FETCH;
      S_JUMP:      w_nextState = S_FETCH;
      S_TRAP:      w_nextState = S_TRAP;
      default:     w_nextState = S_FETCH;
    endcase
  end

  // State register; reset abandons whatever instruction is in flight.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_nextState;
  end

  // Output decode. Everything is Moore from r_state except the FETCH
  // IR/PC load and the SW completion pulse, which follow mem_ready. The
  // whole block is masked by reset so no enable fires on a reset cycle.
  always_comb begin
    bus.mem_req     = 1'b0;
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.BranchNe    = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.MemtoReg    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.RegDst      = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.ALUSrcB     = ALUB_REG;
    bus.ALUOp       = ALUOP_ADD;
    bus.PCSource    = PCSRC_ALU;
    bus.instr_done  = 1'b0;
    bus.illegal     = 1'b0;
    if (!reset) begin
      case (r_state)
        S_FETCH: begin
          bus.mem_req = 1'b1;
          bus.ALUSrcB = ALUB_FOUR;
          bus.IRWrite = bus.mem_ready;
          bus.PCWrite = bus.mem_ready;
        end
        S_DECODE: begin
          bus.ALUSrcB = ALUB_IMM_SH;
          if (!TRAP_ON_ILLEGAL)
            bus.instr_done = !(w_isR || w_isAddi || w_isLw || w_isSw ||
                               w_isBeq || w_isBne || w_isJ);
        end
        S_R_EXEC: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUOp   = ALUOP_FUNCT;
        end
        S_R_WB: begin
          bus.RegDst     = 1'b1;
          bus.RegWrite   = 1'b1;
          bus.instr_done = 1'b1;
        end
        S_I_EXEC, S_MEM_ADDR: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUSrcB = ALUB_IMM;
        end
        S_I_WB: begin
          bus.RegWrite   = 1'b1;
          bus.instr_done = 1'b1;
        end
        S_MEM_READ: begin
          bus.mem_req = 1'b1;
          bus.IorD    = 1'b1;
        end
        S_MEM_WB: begin
          bus.MemtoReg   = 1'b1;
          bus.RegWrite   = 1'b1;
          bus.instr_done = 1'b1;
        end
        S_MEM_WRITE: begin
          bus.mem_req    = 1'b1;
          bus.IorD       = 1'b1;
          bus.MemWrite   = 1'b1;
          bus.instr_done = bus.mem_ready;
        end
        S_BRANCH: begin
          bus.ALUSrcA     = 1'b1;
          bus.ALUOp       = ALUOP_SUB;
          bus.PCSource    = PCSRC_ALUOUT;
          bus.PCWriteCond = 1'b1;
          bus.BranchNe    = w_isBne;
          bus.instr_done  = 1'b1;
        end
        S_JUMP: begin
          bus.PCSource   = PCSRC_JUMP;
          bus.PCWrite    = 1'b1;
          bus.instr_done = 1'b1;
        end
        S_TRAP:  bus.illegal = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// ---------------------------------------------------------------------------
// tb_mc_control_unit
// Directed, table-driven bench for mc_control_unit. Two instances share the
// clock, reset and stimulus: dutTrap (TRAP_ON_ILLEGAL=1) is checked against
// the vector table; dutNop (TRAP_ON_ILLEGAL=0) is checked by a short
// hand-written illegal-opcode sequence.
// ---------------------------------------------------------------------------
module tb_mc_control_unit;

  // Bundled view of every control output, MSB first.
  typedef struct packed {
    logic       memReq;
    logic       pcWrite;
    logic       pcWriteCond;
    logic       branchNe;
    logic       iorD;
    logic       memWrite;
    logic       memToReg;
    logic       irWrite;
    logic       regWrite;
    logic       regDst;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic [1:0] pcSource;
    logic       instrDone;
    logic       illegal;
  } ctrl_t;

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic       rdy;
    ctrl_t      exp;
    string      name;
  } vec_t;

  // Hand-derived expected output per state. Bits: memReq pcWrite
  // pcWriteCond branchNe iorD memWrite memToReg irWrite regWrite regDst
  // aluSrcA | aluSrcB | aluOp | pcSource | instrDone illegal.
  localparam ctrl_t E_ZERO       = {11'b0_0_0_0_0_0_0_0_0_0_0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
  localparam ctrl_t E_FETCH_RDY  = {11'b1_1_0_0_0_0_0_1_0_0_0, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0};
  localparam ctrl_t E_FETCH_WAIT = {11'b1_0_0_0_0_0_0_0_0_0_0, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0};
  localparam ctrl_t E_DECODE     = {11'b0_0_0_0_0_0_0_0_0_0_0, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0};
  localparam ctrl_t E_DECODE_NOP = {11'b0_0_0_0_0_0_0_0_0_0_0, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0};
  localparam ctrl_t E_R_EXEC     = {11'b0_0_0_0_0_0_0_0_0_0_1, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0};
  localparam ctrl_t E_R_WB       = {11'b0_0_0_0_0_0_0_0_1_1_0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
  localparam ctrl_t E_I_EXEC     = {11'b0_0_0_0_0_0_0_0_0_0_1, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0};
  localparam ctrl_t E_I_WB       = {11'b0_0_0_0_0_0_0_0_1_0_0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
  localparam ctrl_t E_MEM_READ   = {11'b1_0_0_0_1_0_0_0_0_0_0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
  localparam ctrl_t E_MEM_WB     = {11'b0_0_0_0_0_0_1_0_1_0_0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
  localparam ctrl_t E_MEMW_WAIT  = {11'b1_0_0_0_1_1_0_0_0_0_0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
  localparam ctrl_t E_MEMW_DONE  = {11'b1_0_0_0_1_1_0_0_0_0_0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
  localparam ctrl_t E_BEQ        = {11'b0_0_1_0_0_0_0_0_0_0_1, 2'b00, 2'b01, 2'b01, 1'b1, 1'b0};
  localparam ctrl_t E_BNE        = {11'b0_0_1_1_0_0_0_0_0_0_1, 2'b00, 2'b01, 2'b01, 1'b1, 1'b0};
  localparam ctrl_t E_JUMP       = {11'b0_1_0_0_0_0_0_0_0_0_0, 2'b00, 2'b00, 2'b10, 1'b1, 1'b0};
  localparam ctrl_t E_TRAP       = {11'b0_0_0_0_0_0_0_0_0_0_0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1};

  localparam logic [5:0] T_R    = 6'b000000;
  localparam logic [5:0] T_ADDI = 6'b001000;
  localparam logic [5:0] T_LW   = 6'b100011;
  localparam logic [5:0] T_SW   = 6'b101011;
  localparam logic [5:0] T_BEQ  = 6'b000100;
  localparam logic [5:0] T_BNE  = 6'b000101;
  localparam logic [5:0] T_J    = 6'b000010;
  localparam logic [5:0] T_BAD  = 6'b111111;

  logic clk;
  logic reset;
  int   nChecks;
  int   nFails;
  vec_t vecs[$];

  mc_control_unit_if #(.OP_W(6)) busT ();
  mc_control_unit_if #(.OP_W(6)) busN ();

  mc_control_unit #(.OP_W(6), .TRAP_ON_ILLEGAL(1'b1)) dutTrap (
    .clk   (clk),
    .reset (reset),
    .bus   (busT)
  );

  mc_control_unit #(.OP_W(6), .TRAP_ON_ILLEGAL(1'b0)) dutNop (
    .clk   (clk),
    .reset (reset),
    .bus   (busN)
  );

  // Free-running 10-time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic ctrl_t sampleOut(input bit useNop);
    ctrl_t c;
    if (useNop)
      c = {busN.mem_req, busN.PCWrite, busN.PCWriteCond, busN.BranchNe, busN.IorD,
           busN.MemWrite, busN.MemtoReg, busN.IRWrite, busN.RegWrite, busN.RegDst,
           busN.ALUSrcA, busN.ALUSrcB, busN.ALUOp, busN.PCSource, busN.instr_done,
           busN.illegal};
    else
      c = {busT.mem_req, busT.PCWrite, busT.PCWriteCond, busT.BranchNe, busT.IorD,
           busT.MemWrite, busT.MemtoReg, busT.IRWrite, busT.RegWrite, busT.RegDst,
           busT.ALUSrcA, busT.ALUSrcB, busT.ALUOp, busT.PCSource, busT.instr_done,
           busT.illegal};
    return c;
  endfunction

  task automatic addVec(input logic rst, input logic [5:0] op, input logic rdy,
                        input ctrl_t exp, input string name);
    vec_t v;
    v.rst = rst; v.op = op; v.rdy = rdy; v.exp = exp; v.name = name;
    vecs.push_back(v);
  endtask

  // Drive inputs just after a rising edge, then move to the falling edge for sampling.
  task automatic applyStimulus(input logic rst, input logic [5:0] op, input logic rdy);
    reset          = rst;
    busT.opCode    = op;
    busT.mem_ready = rdy;
    busN.opCode    = op;
    busN.mem_ready = rdy;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input ctrl_t got, input ctrl_t exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %b, expected %b", name, got, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    nChecks = 0;
    nFails  = 0;

    // Reset, then R-type with no waits: 4 cycles.
    addVec(1, T_R, 1, E_ZERO,      "reset_outputs");
    addVec(0, T_R, 1, E_FETCH_RDY, "r_fetch");
    addVec(0, T_R, 1, E_DECODE,    "r_decode");
    addVec(0, T_R, 1, E_R_EXEC,    "r_exec");
    addVec(0, T_R, 1, E_R_WB,      "r_wb");
    // ADDI: 4 cycles, mem_ready low outside FETCH must not matter.
    addVec(0, T_ADDI, 1, E_FETCH_RDY, "addi_fetch");
    addVec(0, T_ADDI, 0, E_DECODE,    "addi_decode");
    addVec(0, T_ADDI, 0, E_I_EXEC,    "addi_exec");
    addVec(0, T_ADDI, 0, E_I_WB,      "addi_wb");
    // J: 3 cycles.
    addVec(0, T_J, 1, E_FETCH_RDY, "j_fetch");
    addVec(0, T_J, 1, E_DECODE,    "j_decode");
    addVec(0, T_J, 1, E_JUMP,      "j_jump");
    // BEQ then BNE: 3 cycles each, differing only in BranchNe.
    addVec(0, T_BEQ, 1, E_FETCH_RDY, "beq_fetch");
    addVec(0, T_BEQ, 1, E_DECODE,    "beq_decode");
    addVec(0, T_BEQ, 1, E_BEQ,       "beq_branch");
    addVec(0, T_BNE, 1, E_FETCH_RDY, "bne_fetch");
    addVec(0, T_BNE, 1, E_DECODE,    "bne_decode");
    addVec(0, T_BNE, 1, E_BNE,       "bne_branch");
    // LW with 2 FETCH waits and 3 MEM_READ waits: 10 cycles.
    addVec(0, T_LW, 0, E_FETCH_WAIT, "lw_fetch_wait1");
    addVec(0, T_LW, 0, E_FETCH_WAIT, "lw_fetch_wait2");
    addVec(0, T_LW, 1, E_FETCH_RDY,  "lw_fetch");
    addVec(0, T_LW, 1, E_DECODE,     "lw_decode");
    addVec(0, T_LW, 1, E_I_EXEC,     "lw_addr");
    addVec(0, T_LW, 0, E_MEM_READ,   "lw_read_wait1");
    addVec(0, T_LW, 0, E_MEM_READ,   "lw_read_wait2");
    addVec(0, T_LW, 0, E_MEM_READ,   "lw_read_wait3");
    addVec(0, T_LW, 1, E_MEM_READ,   "lw_read");
    addVec(0, T_LW, 0, E_MEM_WB,     "lw_wb");
    // SW with one MEM_WRITE wait: MemWrite held two cycles.
    addVec(0, T_SW, 1, E_FETCH_RDY,  "sw_fetch");
    addVec(0, T_SW, 1, E_DECODE,     "sw_decode");
    addVec(0, T_SW, 1, E_I_EXEC,     "sw_addr");
    addVec(0, T_SW, 0, E_MEMW_WAIT,  "sw_write_wait");
    addVec(0, T_SW, 1, E_MEMW_DONE,  "sw_write");
    // SW interrupted by reset in MEM_WRITE.
    addVec(0, T_SW, 1, E_FETCH_RDY,  "swr_fetch");
    addVec(0, T_SW, 1, E_DECODE,     "swr_decode");
    addVec(0, T_SW, 1, E_I_EXEC,     "swr_addr");
    addVec(1, T_SW, 0, E_ZERO,       "swr_reset_in_write");
    addVec(0, T_SW, 0, E_FETCH_WAIT, "swr_back_to_fetch");
    // Illegal opcode traps and stays there regardless of mem_ready.
    addVec(0, T_BAD, 1, E_FETCH_RDY, "bad_fetch");
    addVec(0, T_BAD, 1, E_DECODE,    "bad_decode");
    for (int i = 0; i < 20; i++)
      addVec(0, T_BAD, logic'(i % 2), E_TRAP, $sformatf("trap_hold%0d", i));
    addVec(1, T_BAD, 1, E_ZERO,       "trap_reset");
    addVec(0, T_BAD, 0, E_FETCH_WAIT, "trap_exit_fetch");

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].op, vecs[i].rdy);
      checkOutput(vecs[i].name, sampleOut(1'b0), vecs[i].exp);
      nextCycle();
    end

    // NOP treatment of an unknown opcode on the non-trapping instance.
    applyStimulus(1, T_BAD, 1);
    checkOutput("nop_reset", sampleOut(1'b1), E_ZERO);
    nextCycle();
    applyStimulus(0, T_BAD, 1);
    checkOutput("nop_fetch", sampleOut(1'b1), E_FETCH_RDY);
    nextCycle();
    applyStimulus(0, T_BAD, 1);
    checkOutput("nop_decode_done", sampleOut(1'b1), E_DECODE_NOP);
    nextCycle();
    applyStimulus(0, T_BAD, 0);
    checkOutput("nop_back_to_fetch", sampleOut(1'b1), E_FETCH_WAIT);
    nextCycle();

    // Trapping instance saw the same sequence and must be in TRAP now.
    applyStimulus(0, T_R, 1);
    checkOutput("trap_after_bad", sampleOut(1'b0), E_TRAP);
    nextCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
